// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multi-cycle MIPS controller
//
// Purpose: opcode/funct constants, ALU operation codes, controller state
// encoding, ALU decode classes and datapath mux-select values.
// Ports: none (package).

package mips_pkg;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes, instr[5:0]
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLL = 3'b011,
    ALU_SRL = 3'b100,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_t;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    R_EXEC,
    ALU_WB,
    I_EXEC,
    I_WB,
    BRANCH,
    JUMP,
    JR,
    ILLEGAL
  } ctrl_state_t;

  // What the current state asks of the ALU decoder
  typedef enum logic [1:0] {
    ALU_CLS_ADD,  // fixed add (fetch, decode, address calc)
    ALU_CLS_SUB,  // fixed subtract (branch compare)
    ALU_CLS_R,    // decode from funct
    ALU_CLS_I     // decode from opcode (addi/slti)
  } alu_cls_t;

  localparam logic [1:0] SRC_A_PC = 2'd0;
  localparam logic [1:0] SRC_A_RS = 2'd1;
  localparam logic [1:0] SRC_A_RT = 2'd2;

  localparam logic [2:0] SRC_B_RT     = 3'd0;
  localparam logic [2:0] SRC_B_FOUR   = 3'd1;
  localparam logic [2:0] SRC_B_IMM    = 3'd2;
  localparam logic [2:0] SRC_B_IMM_SH = 3'd3;
  localparam logic [2:0] SRC_B_SHAMT  = 3'd4;

  localparam logic [1:0] PC_SRC_ALU     = 2'd0;
  localparam logic [1:0] PC_SRC_ALU_REG = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP    = 2'd2;
  localparam logic [1:0] PC_SRC_RS      = 2'd3;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALU operation decode
//
// Purpose: maps the controller's ALU class plus opcode/funct to an ALU code.
// Ports:
//   cls            in   ALU class requested by the current state
//   operation      in   instr[31:26]
//   func           in   instr[5:0]
//   alu_controller out  ALU operation code
//   r_legal        out  funct is a supported R-type ALU operation
//   r_shift        out  funct is a shift (operands come from rt/shamt)

import mips_pkg::*;

module alu_decoder (
  input  alu_cls_t   cls,
  input  logic [5:0] operation,
  input  logic [5:0] func,
  output alu_ctrl_t  alu_controller,
  output logic       r_legal,
  output logic       r_shift
);

  always_comb begin
    alu_controller = ALU_ADD;
    r_legal        = 1'b0;
    r_shift        = 1'b0;
    case (cls)
      ALU_CLS_ADD: alu_controller = ALU_ADD;
      ALU_CLS_SUB: alu_controller = ALU_SUB;
      ALU_CLS_I:   alu_controller = (operation == OP_SLTI) ? ALU_SLT : ALU_ADD;
      ALU_CLS_R: begin
        r_legal = 1'b1;
        case (func)
          FN_ADD:  alu_controller = ALU_ADD;
          FN_SUB:  alu_controller = ALU_SUB;
          FN_AND:  alu_controller = ALU_AND;
          FN_OR:   alu_controller = ALU_OR;
          FN_SLT:  alu_controller = ALU_SLT;
          FN_SLL: begin
            alu_controller = ALU_SLL;
            r_shift        = 1'b1;
          end
          FN_SRL: begin
            alu_controller = ALU_SRL;
            r_shift        = 1'b1;
          end
          default: begin
            alu_controller = ALU_AND;
            r_legal        = 1'b0;
          end
        endcase
      end
      default: alu_controller = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - Moore FSM sequencing the multi-cycle MIPS datapath
//
// Purpose: fetch/decode/execute/memory/write-back sequencing, one instruction
// in flight, 3-5 cycles per instruction.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   operation, func instruction opcode and funct fields
//   zero            ALU zero flag (current cycle)
//   reg_we, reg_write_addr, reg_write_data   register-file write controls
//   instr_reg_we, instr_or_data              IR load, memory address select
//   pc_reg_we, pc_src                        PC load and source
//   alu_src_a, alu_src_b, alu_controller     ALU operand selects and op
//   mem_we                                   data-memory write enable
//   instr_done      pulse in the final state of each instruction
//   illegal_instr   high in ILLEGAL, or a pulse on NOP-decode of an unknown instr

import mips_pkg::*;

module multi_cycle_controller #(
  parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] operation,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       reg_we,
  output logic       reg_write_addr,
  output logic       reg_write_data,
  output logic       instr_reg_we,
  output logic       instr_or_data,
  output logic       pc_reg_we,
  output logic [1:0] alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] pc_src,
  output alu_ctrl_t  alu_controller,
  output logic       mem_we,
  output logic       instr_done,
  output logic       illegal_instr
);

  ctrl_state_t state, next_state;
  alu_cls_t    alu_cls;
  alu_ctrl_t   dec_alu;
  logic        r_legal;
  logic        r_shift;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  // Kept apart from the main decode so the decoder feeds back without a loop
  always_comb begin
    case (state)
      R_EXEC:  alu_cls = ALU_CLS_R;
      I_EXEC:  alu_cls = ALU_CLS_I;
      BRANCH:  alu_cls = ALU_CLS_SUB;
      default: alu_cls = ALU_CLS_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .cls            (alu_cls),
    .operation      (operation),
    .func           (func),
    .alu_controller (dec_alu),
    .r_legal        (r_legal),
    .r_shift        (r_shift)
  );

  always_comb begin
    next_state     = state;
    reg_we         = 1'b0;
    reg_write_addr = 1'b0;
    reg_write_data = 1'b0;
    instr_reg_we   = 1'b0;
    instr_or_data  = 1'b0;
    pc_reg_we      = 1'b0;
    alu_src_a      = SRC_A_PC;
    alu_src_b      = SRC_B_RT;
    pc_src         = PC_SRC_ALU;
    alu_controller = ALU_AND;
    mem_we         = 1'b0;
    instr_done     = 1'b0;
    illegal_instr  = 1'b0;

    case (state)
      FETCH: begin
        instr_reg_we   = 1'b1;
        alu_src_a      = SRC_A_PC;
        alu_src_b      = SRC_B_FOUR;
        alu_controller = ALU_ADD;
        pc_src         = PC_SRC_ALU;
        pc_reg_we      = 1'b1;
        next_state     = DECODE;
      end
      DECODE: begin
        // Branch target is computed speculatively into the ALU register
        alu_src_a      = SRC_A_PC;
        alu_src_b      = SRC_B_IMM_SH;
        alu_controller = dec_alu;
        case (operation)
          OP_LW, OP_SW:    next_state = MEM_ADR;
          OP_RTYPE:        next_state = (func == FN_JR) ? JR : R_EXEC;
          OP_BEQ, OP_BNE:  next_state = BRANCH;
          OP_ADDI, OP_SLTI: next_state = I_EXEC;
          OP_J:            next_state = JUMP;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              next_state = ILLEGAL;
            end else begin
              next_state    = FETCH;
              illegal_instr = 1'b1;
            end
          end
        endcase
      end
      MEM_ADR: begin
        alu_src_a      = SRC_A_RS;
        alu_src_b      = SRC_B_IMM;
        alu_controller = dec_alu;
        next_state     = (operation == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        instr_or_data = 1'b1;
        next_state    = MEM_WB;
      end
      MEM_WB: begin
        reg_we         = 1'b1;
        reg_write_addr = 1'b0;
        reg_write_data = 1'b1;
        instr_done     = 1'b1;
        next_state     = FETCH;
      end
      MEM_WRITE: begin
        instr_or_data = 1'b1;
        mem_we        = 1'b1;
        instr_done    = 1'b1;
        next_state    = FETCH;
      end
      R_EXEC: begin
        if (r_legal) begin
          alu_controller = dec_alu;
          alu_src_a      = r_shift ? SRC_A_RT : SRC_A_RS;
          alu_src_b      = r_shift ? SRC_B_SHAMT : SRC_B_RT;
          next_state     = ALU_WB;
        end else if (TRAP_ON_ILLEGAL) begin
          next_state = ILLEGAL;
        end else begin
          next_state    = FETCH;
          illegal_instr = 1'b1;
        end
      end
      ALU_WB: begin
        reg_we         = 1'b1;
        reg_write_addr = 1'b1;
        reg_write_data = 1'b0;
        instr_done     = 1'b1;
        next_state     = FETCH;
      end
      I_EXEC: begin
        alu_src_a      = SRC_A_RS;
        alu_src_b      = SRC_B_IMM;
        alu_controller = dec_alu;
        next_state     = I_WB;
      end
      I_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        alu_src_a      = SRC_A_RS;
        alu_src_b      = SRC_B_RT;
        alu_controller = dec_alu;
        pc_src         = PC_SRC_ALU_REG;
        pc_reg_we      = (operation == OP_BNE) ? ~zero : zero;
        instr_done     = 1'b1;
        next_state     = FETCH;
      end
      JUMP: begin
        pc_src     = PC_SRC_JUMP;
        pc_reg_we  = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      JR: begin
        pc_src     = PC_SRC_RS;
        pc_reg_we  = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      ILLEGAL: begin
        illegal_instr = 1'b1;
        next_state    = ILLEGAL;
      end
      default: next_state = FETCH;
    endcase

    // Reset blanks every control so an aborted instruction writes nothing
    if (rst) begin
      reg_we         = 1'b0;
      reg_write_addr = 1'b0;
      reg_write_data = 1'b0;
      instr_reg_we   = 1'b0;
      instr_or_data  = 1'b0;
      pc_reg_we      = 1'b0;
      alu_src_a      = SRC_A_PC;
      alu_src_b      = SRC_B_RT;
      pc_src         = PC_SRC_ALU;
      alu_controller = ALU_AND;
      mem_we         = 1'b0;
      instr_done     = 1'b0;
      illegal_instr  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - scoreboard bench for multi_cycle_controller

module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] operation = 6'd0;
  logic [5:0] func = 6'd0;
  logic       zero = 1'b0;
  logic       reg_we, reg_write_addr, reg_write_data, instr_reg_we, instr_or_data, pc_reg_we;
  logic [1:0] alu_src_a, pc_src;
  logic [2:0] alu_src_b, alu_controller;
  logic       mem_we, instr_done, illegal_instr;

  logic       rst2 = 1'b1;
  logic [5:0] op2 = 6'd0;
  logic [5:0] func2 = 6'd0;
  logic       zero2 = 1'b0;
  logic       reg_we2, reg_write_addr2, reg_write_data2, instr_reg_we2, instr_or_data2, pc_reg_we2;
  logic [1:0] alu_src_a2, pc_src2;
  logic [2:0] alu_src_b2, alu_controller2;
  logic       mem_we2, instr_done2, illegal_instr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_cycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .rst(rst), .operation(operation), .func(func), .zero(zero),
    .reg_we(reg_we), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .instr_reg_we(instr_reg_we), .instr_or_data(instr_or_data), .pc_reg_we(pc_reg_we),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_controller(alu_controller), .mem_we(mem_we), .instr_done(instr_done),
    .illegal_instr(illegal_instr)
  );

  multi_cycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut_trap (
    .clk(clk), .rst(rst2), .operation(op2), .func(func2), .zero(zero2),
    .reg_we(reg_we2), .reg_write_addr(reg_write_addr2), .reg_write_data(reg_write_data2),
    .instr_reg_we(instr_reg_we2), .instr_or_data(instr_or_data2), .pc_reg_we(pc_reg_we2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .pc_src(pc_src2),
    .alu_controller(alu_controller2), .mem_we(mem_we2), .instr_done(instr_done2),
    .illegal_instr(illegal_instr2)
  );

  logic [18:0] act, act2;
  assign act  = {reg_we, reg_write_addr, reg_write_data, instr_reg_we, instr_or_data,
                 pc_reg_we, alu_src_a, alu_src_b, pc_src, alu_controller, mem_we,
                 instr_done, illegal_instr};
  assign act2 = {reg_we2, reg_write_addr2, reg_write_data2, instr_reg_we2, instr_or_data2,
                 pc_reg_we2, alu_src_a2, alu_src_b2, pc_src2, alu_controller2, mem_we2,
                 instr_done2, illegal_instr2};

  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_SLL = 3'b011;
  localparam logic [2:0] A_SRL = 3'b100, A_SUB = 3'b110, A_SLT = 3'b111;

  function automatic logic [18:0] mk(input logic rwe, input logic rwa, input logic rwd,
                                     input logic irwe, input logic iod, input logic pcwe,
                                     input logic [1:0] sa, input logic [2:0] sb,
                                     input logic [1:0] ps, input logic [2:0] alu,
                                     input logic mwe, input logic done, input logic ill);
    return {rwe, rwa, rwd, irwe, iod, pcwe, sa, sb, ps, alu, mwe, done, ill};
  endfunction

  logic [18:0] exp_q[$];
  logic [18:0] steps[$];
  int          step_no = 0;

  // Monitor: one expected control word per cycle while the scoreboard holds any
  always @(negedge clk) begin
    logic [18:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL ctrl_word step %0d op=%b func=%b zero=%b: got %b want %b",
                 step_no, operation, func, zero, act, e);
      end
      step_no++;
    end
  end

  // Reference model: the control words an instruction must produce, cycle by cycle
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic       known;
    logic [2:0] r_alu;
    logic       r_ok, r_sh;
    steps.delete();
    known = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
            (op == 6'b000100) || (op == 6'b000101) || (op == 6'b001000) ||
            (op == 6'b001010) || (op == 6'b000010);
    steps.push_back(mk(0,0,0,1,0,1,2'd0,3'd1,2'd0,A_ADD,0,0,0));
    steps.push_back(mk(0,0,0,0,0,0,2'd0,3'd3,2'd0,A_ADD,0,0,!known));
    if (!known) return;
    case (op)
      6'b100011: begin
        steps.push_back(mk(0,0,0,0,0,0,2'd1,3'd2,2'd0,A_ADD,0,0,0));
        steps.push_back(mk(0,0,0,0,1,0,2'd0,3'd0,2'd0,A_AND,0,0,0));
        steps.push_back(mk(1,0,1,0,0,0,2'd0,3'd0,2'd0,A_AND,0,1,0));
      end
      6'b101011: begin
        steps.push_back(mk(0,0,0,0,0,0,2'd1,3'd2,2'd0,A_ADD,0,0,0));
        steps.push_back(mk(0,0,0,0,1,0,2'd0,3'd0,2'd0,A_AND,1,1,0));
      end
      6'b000000: begin
        if (fn == 6'b001000) begin
          steps.push_back(mk(0,0,0,0,0,1,2'd0,3'd0,2'd3,A_AND,0,1,0));
        end else begin
          r_ok = 1'b1;
          r_sh = 1'b0;
          r_alu = A_AND;
          case (fn)
            6'b100000: r_alu = A_ADD;
            6'b100010: r_alu = A_SUB;
            6'b100100: r_alu = A_AND;
            6'b100101: r_alu = A_OR;
            6'b101010: r_alu = A_SLT;
            6'b000000: begin r_alu = A_SLL; r_sh = 1'b1; end
            6'b000010: begin r_alu = A_SRL; r_sh = 1'b1; end
            default:   r_ok = 1'b0;
          endcase
          if (!r_ok) begin
            steps.push_back(mk(0,0,0,0,0,0,2'd0,3'd0,2'd0,A_AND,0,0,1));
          end else begin
            steps.push_back(mk(0,0,0,0,0,0, r_sh ? 2'd2 : 2'd1, r_sh ? 3'd4 : 3'd0,
                               2'd0, r_alu, 0,0,0));
            steps.push_back(mk(1,1,0,0,0,0,2'd0,3'd0,2'd0,A_AND,0,1,0));
          end
        end
      end
      6'b000100, 6'b000101: begin
        steps.push_back(mk(0,0,0,0,0, (op == 6'b000100) ? z : !z, 2'd1,3'd0,2'd1,A_SUB,0,1,0));
      end
      6'b001000, 6'b001010: begin
        steps.push_back(mk(0,0,0,0,0,0,2'd1,3'd2,2'd0,
                           (op == 6'b001010) ? A_SLT : A_ADD, 0,0,0));
        steps.push_back(mk(1,0,0,0,0,0,2'd0,3'd0,2'd0,A_AND,0,1,0));
      end
      default: begin
        steps.push_back(mk(0,0,0,0,0,1,2'd0,3'd0,2'd2,A_AND,0,1,0));
      end
    endcase
  endtask

  // Issue the first n steps of the built instruction and wait them out
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
    operation = op;
    func = fn;
    zero = z;
    for (int i = 0; i < n; i++) exp_q.push_back(steps[i]);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    build(op, fn, z);
    issue(op, fn, z, steps.size());
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(19'd0);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk2(input string name, input logic [18:0] want);
    @(negedge clk);
    checks++;
    if (act2 !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act2, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] op, fn;
    logic       z;
    int         pick;
    int         k;

    @(posedge clk);
    #1;
    do_reset(2);

    // Directed patterns
    run_instr(6'b100011, 6'h15, 1'b0);
    run_instr(6'b101011, 6'h00, 1'b1);
    run_instr(6'b000100, 6'h00, 1'b1);
    run_instr(6'b000100, 6'h00, 1'b0);
    run_instr(6'b000101, 6'h00, 1'b1);
    run_instr(6'b000101, 6'h00, 1'b0);
    run_instr(6'b000000, 6'b000000, 1'b0);
    run_instr(6'b000000, 6'b101010, 1'b0);
    run_instr(6'b000000, 6'b001000, 1'b0);
    run_instr(6'b111111, 6'h00, 1'b0);
    run_instr(6'b000000, 6'b111111, 1'b0);
    run_instr(6'b001000, 6'h00, 1'b0);
    run_instr(6'b001010, 6'h00, 1'b0);
    run_instr(6'b000010, 6'h00, 1'b0);

    // Reset held two cycles while the lw is in its memory-read cycle
    build(6'b100011, 6'h00, 1'b0);
    issue(6'b100011, 6'h00, 1'b0, 3);
    do_reset(2);
    run_instr(6'b100011, 6'h00, 1'b0);

    // Randomized mix, with occasional mid-instruction resets
    for (int n = 0; n < 400; n++) begin
      pick = $urandom_range(0, 15);
      fn = 6'($urandom);
      z = 1'($urandom);
      case (pick)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000100;
        3: op = 6'b000101;
        4: op = 6'b001000;
        5: op = 6'b001010;
        6: op = 6'b000010;
        7: begin op = 6'b000000; fn = 6'b001000; end
        8: begin op = 6'b000000; fn = 6'b100000; end
        9: begin op = 6'b000000; fn = 6'b100010; end
        10: begin op = 6'b000000; fn = 6'b100100; end
        11: begin op = 6'b000000; fn = 6'b100101; end
        12: begin op = 6'b000000; fn = 6'b101010; end
        13: begin op = 6'b000000; fn = {4'b0000, 1'($urandom), 1'b0}; end
        14: op = 6'b000000;
        default: op = 6'($urandom);
      endcase
      build(op, fn, z);
      if ($urandom_range(0, 19) == 0) begin
        k = $urandom_range(1, steps.size());
        issue(op, fn, z, k);
        do_reset($urandom_range(1, 3));
      end else begin
        issue(op, fn, z, steps.size());
      end
    end

    // Trapping instance: unknown opcode parks until reset
    rst2 = 1'b0;
    op2 = 6'b111111;
    chk2("trap_fetch", mk(0,0,0,1,0,1,2'd0,3'd1,2'd0,A_ADD,0,0,0));
    chk2("trap_decode", mk(0,0,0,0,0,0,2'd0,3'd3,2'd0,A_ADD,0,0,0));
    for (int i = 0; i < 4; i++) chk2("trap_parked", mk(0,0,0,0,0,0,2'd0,3'd0,2'd0,A_AND,0,0,1));
    op2 = 6'b100011;
    for (int i = 0; i < 3; i++) chk2("trap_parked_lw", mk(0,0,0,0,0,0,2'd0,3'd0,2'd0,A_AND,0,0,1));
    rst2 = 1'b1;
    chk2("trap_in_reset", 19'd0);
    rst2 = 1'b0;
    op2 = 6'b000000;
    func2 = 6'b111111;
    chk2("trap_refetch", mk(0,0,0,1,0,1,2'd0,3'd1,2'd0,A_ADD,0,0,0));
    chk2("trap_r_decode", mk(0,0,0,0,0,0,2'd0,3'd3,2'd0,A_ADD,0,0,0));
    chk2("trap_r_exec", 19'd0);
    for (int i = 0; i < 3; i++) chk2("trap_r_parked", mk(0,0,0,0,0,0,2'd0,3'd0,2'd0,A_AND,0,0,1));

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
